// File: rtl/pv_ctrl_pkg.sv
// ============================================================================
// Module      : pv_ctrl_pkg
// Description : Shared definitions for the pv_ctrl word protocol: the
//               generator state encoding, control-word bit positions and a
//               pack function that builds a control word. The PV evaluator
//               bench imports the same pack function so both ends agree on
//               the word layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pv_ctrl_pkg;

  // Generator states. FILL is only reachable when the fill option is built in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } pv_state_t;

  // Fixed command bits at the top of every control word.
  localparam int WRITE_BIT = 31;
  localparam int CLEAR_BIT = 30;

  // The entry field always starts at bit 0.
  localparam int ENTRY_LSB = 0;

  // Ply field sits directly above the UCI entry.
  function automatic int ply_lsb(input int uci_w);
    return uci_w;
  endfunction

  // entry_valid flag sits directly above the ply field.
  function automatic int valid_bit(input int uci_w, input int ply_w);
    return uci_w + ply_w;
  endfunction

  // Build one control word. Fields wider than their slot are masked so a
  // caller can pass zero-extended values without worrying about overlap.
  function automatic logic [31:0] pack_word(
    input logic        wr,
    input logic        clr,
    input logic        entry_valid,
    input logic [31:0] ply,
    input logic [31:0] entry,
    input int          uci_w,
    input int          ply_w
  );
    logic [31:0] entry_mask;
    logic [31:0] ply_mask;
    logic [31:0] word;
    entry_mask = (32'd1 << uci_w) - 32'd1;
    ply_mask   = (32'd1 << ply_w) - 32'd1;
    word       = ((entry & entry_mask) << ENTRY_LSB)
               | ((ply & ply_mask) << ply_lsb(uci_w));
    word       = word | (32'(entry_valid) << valid_bit(uci_w, ply_w));
    word       = word | (32'(wr) << WRITE_BIT) | (32'(clr) << CLEAR_BIT);
    return word;
  endfunction

endpackage : pv_ctrl_pkg

`default_nettype wire

// File: rtl/pv_ctrl_gen.sv
// ============================================================================
// Module      : pv_ctrl_gen
// Description : Transmit end of the pv_ctrl word protocol. Converts a
//               ply-ordered UCI move stream into one clear word followed by
//               one write word per ply on the broadcast pv_ctrl bus, then
//               pulses done.
//               Build option: define PV_CTRL_GEN_FILL_EN to append write
//               words with entry_valid=0 for every ply past the PV length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pv_ctrl_gen
  import pv_ctrl_pkg::*;
#(
  parameter int UCI_WIDTH      = 16,
  parameter int MAX_DEPTH_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pv_start,
  input  logic [MAX_DEPTH_LOG2:0] pv_length,
  input  logic                    pv_abort,
  input  logic                    move_valid,
  input  logic [UCI_WIDTH-1:0]    move_uci,
  output logic                    move_ready,
  output logic [31:0]             pv_ctrl_out,
  output logic                    busy,
  output logic                    done
);

  // Ply counter and length are one bit wider than the ply field so they can
  // hold the full table depth.
  localparam int PW        = MAX_DEPTH_LOG2 + 1;
  localparam int MAX_DEPTH = 2 ** MAX_DEPTH_LOG2;
  localparam int LAST_IDX  = MAX_DEPTH - 1;

  localparam logic [PW-1:0] DEPTH_CNT = MAX_DEPTH[PW-1:0];
  localparam logic [PW-1:0] LAST_PLY  = LAST_IDX[PW-1:0];
  localparam logic [PW-1:0] PLY_ONE   = {{MAX_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PLY_ZERO  = '0;

  // The entry, ply and valid fields must all sit below the clear bit.
  if (UCI_WIDTH + MAX_DEPTH_LOG2 + 1 > 30) begin : g_width_check
    $error("pv_ctrl_gen: UCI_WIDTH + MAX_DEPTH_LOG2 + 1 must not exceed 30");
  end

  pv_state_t      state;
  pv_state_t      state_nxt;
  logic [PW-1:0]  ply;
  logic [PW-1:0]  ply_nxt;
  logic [PW-1:0]  len;
  logic [PW-1:0]  len_nxt;
  logic [PW-1:0]  len_clamped;
  logic [31:0]    word_nxt;
  logic           busy_nxt;
  logic           done_nxt;

  // Requests longer than the table are clamped so the ply counter never
  // has to wrap.
  assign len_clamped = (pv_length > DEPTH_CNT) ? DEPTH_CNT : pv_length;

  // Next-state, next-output and move handshake decode.
  always_comb begin
    state_nxt  = state;
    ply_nxt    = ply;
    len_nxt    = len;
    word_nxt   = 32'h0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    move_ready = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pv_start && !busy) begin
          len_nxt   = len_clamped;
          ply_nxt   = PLY_ZERO;
          busy_nxt  = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        word_nxt = pack_word(1'b0, 1'b1, 1'b0, 32'h0, 32'h0,
                             UCI_WIDTH, MAX_DEPTH_LOG2);
        if (len != PLY_ZERO) begin
          state_nxt = ST_WRITE;
        end else begin
`ifdef PV_CTRL_GEN_FILL_EN
          state_nxt = ST_FILL;
`else
          state_nxt = ST_DONE;
`endif
        end
      end

      ST_WRITE: begin
        move_ready = 1'b1;
        if (move_valid) begin
          word_nxt = pack_word(1'b1, 1'b0, 1'b1, 32'(ply), 32'(move_uci),
                               UCI_WIDTH, MAX_DEPTH_LOG2);
          ply_nxt  = ply + PLY_ONE;
          if (ply == len - PLY_ONE) begin
`ifdef PV_CTRL_GEN_FILL_EN
            state_nxt = (len == DEPTH_CNT) ? ST_DONE : ST_FILL;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end

`ifdef PV_CTRL_GEN_FILL_EN
      ST_FILL: begin
        // Wipe every ply past the loaded PV, one per cycle.
        word_nxt = pack_word(1'b1, 1'b0, 1'b0, 32'(ply), 32'h0,
                             UCI_WIDTH, MAX_DEPTH_LOG2);
        ply_nxt  = ply + PLY_ONE;
        if (ply == LAST_PLY) begin
          state_nxt = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // Abort wins over everything, including a same-cycle move handshake,
    // so the move is left for the source to present again.
    if (pv_abort && (state != ST_IDLE)) begin
      state_nxt  = ST_IDLE;
      ply_nxt    = ply;
      word_nxt   = 32'h0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      move_ready = 1'b0;
    end
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ply         <= PLY_ZERO;
      len         <= PLY_ZERO;
      pv_ctrl_out <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ply         <= ply_nxt;
      len         <= len_nxt;
      pv_ctrl_out <= word_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule : pv_ctrl_gen

`default_nettype wire
